bcd2b: RTL and testbench

Registered BCD-to-binary converter. It accepts a packed BCD value of one or more decimal digits and produces the equivalent unsigned binary value. It also produces an `invalid` flag when any digit nibble holds a non-decimal code (10–15). It sits on the datapath between decimal-entry/display logic and binary arithmetic, and is fully pipelined with one value accepted per clock.

---
 rtl/bcd2b.sv | 59 +++++
 tb/tb_bcd2b.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bcd2b.sv
// Registered packed-BCD to unsigned binary converter with a non-decimal-digit flag.
// One value accepted per clock, one cycle of latency.
module bcd2b #(
    parameter int unsigned DIGITS = 1,
    parameter int unsigned BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  invalid
);

    localparam int unsigned BCD_W = 4 * DIGITS;

    // 2^BIN_W >= 10^DIGITS  <=>  BIN_W * log10(2) >= DIGITS (never exactly equal)
    localparam real LOG10_2 = 0.30102999566398120;

    generate
        if (DIGITS < 1) begin : g_bad_digits
            $error("bcd2b: DIGITS must be at least 1");
        end
        if (real'(BIN_W) * LOG10_2 < real'(DIGITS)) begin : g_bad_width
            $error("bcd2b: BIN_W too narrow to hold 10^DIGITS - 1");
        end
    endgenerate

    logic [BIN_W-1:0] bin_c;
    logic             invalid_c;
    logic [BIN_W-1:0] acc_c;

    // Horner accumulation from the most significant digit: acc = acc*10 + digit
    always_comb begin
        logic [3:0] digit;
        acc_c     = '0;
        invalid_c = 1'b0;
        digit     = 4'd0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            digit     = bcd[4*i +: 4];
            invalid_c = invalid_c | (digit[3] & (digit[2] | digit[1]));
            acc_c     = (acc_c << 3) + (acc_c << 1) + BIN_W'(digit);
        end
        bin_c = invalid_c ? '0 : acc_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin     <= '0;
            invalid <= 1'b0;
        end else begin
            bin     <= bin_c;
            invalid <= invalid_c;
        end
    end

    logic unused_c;
    assign unused_c = ^BCD_W;

endmodule

// File: tb/tb_bcd2b.sv
// Scoreboard bench for bcd2b: a 1-digit/8-bit instance and a 2-digit/7-bit instance
// run in lockstep; stimulus pushes expected results, a monitor pops and compares.
module tb_bcd2b;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd1 = 4'd7;
    logic [7:0] bcd2 = 8'h00;
    logic [7:0] bin1;
    logic       inv1;
    logic [6:0] bin2;
    logic       inv2;

    logic [8:0] q1[$];
    logic [7:0] q2[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd2b #(.DIGITS(1), .BIN_W(8)) u_d1 (
        .clk(clk), .rst(rst), .bcd(bcd1), .bin(bin1), .invalid(inv1)
    );

    bcd2b #(.DIGITS(2), .BIN_W(7)) u_d2 (
        .clk(clk), .rst(rst), .bcd(bcd2), .bin(bin2), .invalid(inv2)
    );

    // Monitor: outputs are valid every cycle, so one pop per queue per edge
    always begin
        logic [8:0] e1;
        logic [7:0] e2;
        @(posedge clk);
        #1;
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            n_cmp++;
            if ({inv1, bin1} !== e1) begin
                n_err++;
                $display("FAIL d1 t=%0t got bin=%0d inv=%b want bin=%0d inv=%b",
                         $time, bin1, inv1, e1[7:0], e1[8]);
            end
        end
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            n_cmp++;
            if ({inv2, bin2} !== e2) begin
                n_err++;
                $display("FAIL d2 t=%0t got bin=%0d inv=%b want bin=%0d inv=%b",
                         $time, bin2, inv2, e2[6:0], e2[7]);
            end
        end
    end

    task automatic apply(input logic r, input logic [3:0] b1, input logic [7:0] x1,
                         input logic i1, input logic [7:0] b2, input logic [6:0] x2,
                         input logic i2);
        @(negedge clk);
        rst  = r;
        bcd1 = b1;
        bcd2 = b2;
        q1.push_back({i1, x1});
        q2.push_back({i2, x2});
    endtask

    task automatic apply1(input logic r, input logic [3:0] b, input logic [7:0] x,
                          input logic i);
        apply(r, b, x, i, 8'h00, 7'd0, 1'b0);
    endtask

    task automatic apply2(input logic r, input logic [7:0] b, input logic [6:0] x,
                          input logic i);
        apply(r, 4'd0, 8'd0, 1'b0, b, x, i);
    endtask

    initial begin
        // Reset held two edges with a live input, then release
        apply1(1'b1, 4'd7, 8'h00, 1'b0);
        apply1(1'b1, 4'd7, 8'h00, 1'b0);
        apply1(1'b0, 4'd7, 8'h07, 1'b0);

        for (int i = 0; i < 10; i++)
            apply1(1'b0, 4'(i), 8'(i), 1'b0);
        for (int i = 10; i < 16; i++)
            apply1(1'b0, 4'(i), 8'h00, 1'b1);
        apply1(1'b0, 4'd3, 8'h03, 1'b0);

        // Streaming sequence
        apply1(1'b0, 4'd9,  8'h09, 1'b0);
        apply1(1'b0, 4'd12, 8'h00, 1'b1);
        apply1(1'b0, 4'd0,  8'h00, 1'b0);
        apply1(1'b0, 4'd5,  8'h05, 1'b0);

        // Mid-stream reset, then resume with the current input
        apply1(1'b0, 4'd4, 8'h04, 1'b0);
        apply1(1'b1, 4'd8, 8'h00, 1'b0);
        apply1(1'b0, 4'd8, 8'h08, 1'b0);

        // Glitches between edges: only the value at the edge counts
        @(negedge clk);
        q1.push_back({1'b0, 8'h06});
        q2.push_back(8'h00);
        bcd1 = 4'd13;
        #1 bcd1 = 4'd2;
        #1 bcd1 = 4'd6;

        // Two-digit instance
        apply2(1'b0, 8'h99, 7'd99, 1'b0);
        apply2(1'b0, 8'h42, 7'd42, 1'b0);
        apply2(1'b0, 8'h4A, 7'd0,  1'b1);
        apply2(1'b0, 8'hA4, 7'd0,  1'b1);
        apply2(1'b0, 8'hFF, 7'd0,  1'b1);
        apply2(1'b0, 8'h10, 7'd10, 1'b0);
        apply2(1'b0, 8'h07, 7'd7,  1'b0);
        apply2(1'b1, 8'h99, 7'd0,  1'b0);
        apply2(1'b0, 8'h99, 7'd99, 1'b0);
        apply2(1'b0, 8'h00, 7'd0,  1'b0);

        // Drain with a bounded wait
        for (int k = 0; k < 10 && (q1.size() > 0 || q2.size() > 0); k++)
            @(negedge clk);
        if (q1.size() > 0 || q2.size() > 0) begin
            n_err++;
            $display("FAIL drain got %0d/%0d pending want 0/0", q1.size(), q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
